hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the RV32 core. Sits directly upstream of the CSR unit and produces its HAZ_Stall, lw_use and branch inputs.
- Also drives PC and IF/ID / ID/EX write-enable and flush controls.
- Merges AXI bus stalls, load-use detection and branch redirects into one prioritised decision.
- Holds a branch redirect that arrives during a bus stall, and keeps saturating performance counters.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
im_stall  in  1  instruction-side AXI master busy
dm_stall  in  1  data-side AXI master busy
ifid_rs1  in  REG_ADDR_W  rs1 of instruction in ID
ifid_rs2  in  REG_ADDR_W  rs2 of instruction in ID
ifid_use_rs1  in  1  ID instruction reads rs1
ifid_use_rs2  in  1  ID instruction reads rs2
idex_rd  in  REG_ADDR_W  rd of instruction in EX
idex_mem_read  in  1  EX instruction is a load
branch_i  in  2  EX redirect pulse: 00 none, 01 conditional taken, 10 jal, 11 jalr; valid one cycle only
HAZ_Stall  out  1  global pipeline freeze (to CSR and all stage registers)
lw_use  out  1  load-use bubble inserted this cycle
branch  out  2  redirect applied this cycle (encoding as branch_i)
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register update enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to NOP
cnt_stall  out  CNT_W  cycles with HAZ_Stall=1
cnt_bubble  out  CNT_W  cycles with lw_use=1
cnt_flush  out  CNT_W  redirects applied

Behaviour:
- Reset state: state=RUN, pend_br=00, all counters 0.
- While rst=1, outputs are forced: HAZ_Stall=0, lw_use=0, branch=00, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
- Reset mid-operation discards pend_br and any in-progress WAIT state.
- FSM states:
  - RUN: normal operation. Moves to WAIT when im_stall|dm_stall.
  - WAIT: bus stall in progress. Moves to RUN in the first cycle where im_stall=dm_stall=0; that cycle is evaluated with RUN rules.
- HAZ_Stall = im_stall|dm_stall, combinational, zero latency, in either state.
- Stalled cycle (HAZ_Stall=1):
  - pc_write=0, ifid_write=0, flushes=0, lw_use=0, branch=00.
  - If branch_i!=00, it is latched into pend_br; a later nonzero branch_i overwrites it.
- Unstalled cycle, priority redirect > load-use:
  - Effective redirect eff = pend_br if pend_br!=00, else branch_i. If both are nonzero, pend_br wins and branch_i is dropped.
  - eff!=00: branch=eff, ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1, lw_use=0. pend_br cleared at the clock edge.
  - Else lw_use=1 when idex_mem_read & idex_rd!=0 & ((ifid_use_rs1 & idex_rd==ifid_rs1) | (ifid_use_rs2 & idex_rd==ifid_rs2)).
    - In that case: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
  - Else: pc_write=1, ifid_write=1, both flushes 0.
- Load-use bubble lasts exactly one cycle; the next cycle the load is in MEM and no longer matches.
- rd=x0 never triggers lw_use.
- Counters:
  - Each increments by 1 at the clock edge when its condition holds.
  - Each saturates at all-ones; no wrap.
  - cnt_flush counts cycles with branch!=00.

Test Plan:
- Reset release, no hazards, 10 cycles -> pc_write=ifid_write=1, all flushes 0, counters stay 0.
- idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 for one cycle -> lw_use=1, pc_write=0, idex_flush=1 that cycle; cnt_bubble=1.
- Same load-use with idex_rd=0 -> lw_use=0, no bubble.
- dm_stall=1 for cycles 3-6, branch_i=10 pulsed in cycle 4 -> HAZ_Stall=1 in cycles 3-6, branch=00 throughout. Cycle 7: branch=10, both flushes 1. cnt_stall=4, cnt_flush=1.
- branch_i=01 and load-use match in the same cycle -> branch=01, lw_use=0, cnt_bubble unchanged.
- rst pulsed during WAIT with pend_br=11 -> after release, state RUN, branch=00, counters 0.
- cnt_stall preloaded to all-ones via force, im_stall=1 -> cnt_stall holds at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller signal bundle between pipeline and hazard_ctrl
//
// Groups every non-clock/reset signal of hazard_ctrl.
//   master : pipeline side, drives stall/hazard/redirect inputs and observes decisions
//   slave  : hazard_ctrl side, consumes those inputs and drives the pipeline controls
// Signals:
//   im_stall, dm_stall         AXI instruction/data master busy
//   ifid_rs1/rs2, use_rs1/rs2  source registers read by the instruction in ID
//   idex_rd, idex_mem_read     destination and load flag of the instruction in EX
//   branch_i                   one-cycle redirect pulse from EX (00 none, 01 cond, 10 jal, 11 jalr)
//   HAZ_Stall, lw_use, branch  stall / load-use bubble / applied redirect
//   pc_write, ifid_write       stage update enables
//   ifid_flush, idex_flush     stage clears to NOP
//   cnt_stall/bubble/flush     saturating performance counters
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  im_stall;
    logic                  dm_stall;
    logic [REG_ADDR_W-1:0] ifid_rs1;
    logic [REG_ADDR_W-1:0] ifid_rs2;
    logic                  ifid_use_rs1;
    logic                  ifid_use_rs2;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  idex_mem_read;
    logic [1:0]            branch_i;

    logic                  HAZ_Stall;
    logic                  lw_use;
    logic [1:0]            branch;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic [CNT_W-1:0]      cnt_stall;
    logic [CNT_W-1:0]      cnt_bubble;
    logic [CNT_W-1:0]      cnt_flush;

    modport master (
        output im_stall, dm_stall, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_mem_read, branch_i,
        input  HAZ_Stall, lw_use, branch, pc_write, ifid_write, ifid_flush, idex_flush,
               cnt_stall, cnt_bubble, cnt_flush
    );

    modport slave (
        input  im_stall, dm_stall, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_mem_read, branch_i,
        output HAZ_Stall, lw_use, branch, pc_write, ifid_write, ifid_flush, idex_flush,
               cnt_stall, cnt_bubble, cnt_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32 pipeline hazard/stall controller with redirect hold and perf counters
//
// Ports:
//   clk  core clock
//   rst  asynchronous, active-high reset
//   hif  hazard_ctrl_if.slave (bus stalls, load-use operands, redirect pulse in;
//        HAZ_Stall/lw_use/branch, stage enables/flushes and counters out)
//
// Decision priority each cycle: bus stall > redirect (held one first) > load-use bubble.
// Control outputs are combinational so a bus stall freezes the pipeline with zero latency.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
    localparam logic [REG_ADDR_W-1:0] REG_X0  = {REG_ADDR_W{1'b0}};

    state_t           state_q;
    logic [1:0]       pend_br_q;
    logic [CNT_W-1:0] cnt_stall_q;
    logic [CNT_W-1:0] cnt_bubble_q;
    logic [CNT_W-1:0] cnt_flush_q;

    logic       stall;
    logic [1:0] eff_br;
    logic       lu_hit;

    logic       haz_stall_c;
    logic       lw_use_c;
    logic [1:0] branch_c;
    logic       pc_write_c;
    logic       ifid_write_c;
    logic       ifid_flush_c;
    logic       idex_flush_c;

    assign stall = hif.im_stall | hif.dm_stall;

    // A redirect held across a bus stall is older than anything arriving now,
    // so it takes precedence and a simultaneous new pulse is dropped.
    assign eff_br = (pend_br_q != 2'b00) ? pend_br_q : hif.branch_i;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_hit = hif.idex_mem_read && (hif.idex_rd != REG_X0) &&
                    ((hif.ifid_use_rs1 && (hif.idex_rd == hif.ifid_rs1)) ||
                     (hif.ifid_use_rs2 && (hif.idex_rd == hif.ifid_rs2)));

    always_comb begin
        haz_stall_c  = 1'b0;
        lw_use_c     = 1'b0;
        branch_c     = 2'b00;
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        if (rst) begin
            // Hold both stage registers as NOPs while in reset.
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (stall) begin
            haz_stall_c = 1'b1;
        end else if (eff_br != 2'b00) begin
            branch_c     = eff_br;
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (lu_hit) begin
            // Freeze PC and IF/ID, inject a bubble into EX for one cycle.
            lw_use_c     = 1'b1;
            idex_flush_c = 1'b1;
        end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
        end
    end

    // Stall tracking and redirect hold. WAIT exits on the first quiet cycle,
    // which is itself evaluated with normal rules by the logic above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pend_br_q <= 2'b00;
        end else begin
            case (state_q)
                ST_RUN:  if (stall)  state_q <= ST_WAIT;
                ST_WAIT: if (!stall) state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
            if (stall) begin
                if (hif.branch_i != 2'b00) pend_br_q <= hif.branch_i;
            end else if (eff_br != 2'b00) begin
                pend_br_q <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_stall_q  <= '0;
            cnt_bubble_q <= '0;
            cnt_flush_q  <= '0;
        end else begin
            if (haz_stall_c && (cnt_stall_q != CNT_MAX))
                cnt_stall_q <= cnt_stall_q + CNT_ONE;
            if (lw_use_c && (cnt_bubble_q != CNT_MAX))
                cnt_bubble_q <= cnt_bubble_q + CNT_ONE;
            if ((branch_c != 2'b00) && (cnt_flush_q != CNT_MAX))
                cnt_flush_q <= cnt_flush_q + CNT_ONE;
        end
    end

    assign hif.HAZ_Stall  = haz_stall_c;
    assign hif.lw_use     = lw_use_c;
    assign hif.branch     = branch_c;
    assign hif.pc_write   = pc_write_c;
    assign hif.ifid_write = ifid_write_c;
    assign hif.ifid_flush = ifid_flush_c;
    assign hif.idex_flush = idex_flush_c;
    assign hif.cnt_stall  = cnt_stall_q;
    assign hif.cnt_bubble = cnt_bubble_q;
    assign hif.cnt_flush  = cnt_flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hif ();
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hif(hif.slave));

    int total = 0;
    int bad   = 0;

    // Model state
    logic [1:0]  m_pend;
    logic [31:0] m_cs, m_cb, m_cf;

    // Model expectations for the current cycle
    logic       e_haz, e_lw, e_pcw, e_ifw, e_iff, e_idf;
    logic [1:0] e_br;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_eval();
        logic [1:0] eff;
        logic       dep;
        e_haz = 0; e_lw = 0; e_br = 0; e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 0;
        eff = (m_pend != 0) ? m_pend : hif.branch_i;
        dep = hif.idex_mem_read && hif.idex_rd != 0 &&
              ((hif.ifid_use_rs1 && hif.idex_rd == hif.ifid_rs1) ||
               (hif.ifid_use_rs2 && hif.idex_rd == hif.ifid_rs2));
        if (rst) begin
            e_iff = 1; e_idf = 1;
        end else if (hif.im_stall || hif.dm_stall) begin
            e_haz = 1;
        end else if (eff != 0) begin
            e_br = eff; e_pcw = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
        end else if (dep) begin
            e_lw = 1; e_idf = 1;
        end else begin
            e_pcw = 1; e_ifw = 1;
        end
    endtask

    // Inputs are already set at the falling edge; check, clock, advance model.
    task automatic step();
        if (rst) begin
            m_pend = 0; m_cs = 0; m_cb = 0; m_cf = 0;
        end
        #1;
        model_eval();
        chk("HAZ_Stall",  {31'd0, hif.HAZ_Stall},  {31'd0, e_haz});
        chk("lw_use",     {31'd0, hif.lw_use},     {31'd0, e_lw});
        chk("branch",     {30'd0, hif.branch},     {30'd0, e_br});
        chk("pc_write",   {31'd0, hif.pc_write},   {31'd0, e_pcw});
        chk("ifid_write", {31'd0, hif.ifid_write}, {31'd0, e_ifw});
        chk("ifid_flush", {31'd0, hif.ifid_flush}, {31'd0, e_iff});
        chk("idex_flush", {31'd0, hif.idex_flush}, {31'd0, e_idf});
        chk("cnt_stall",  hif.cnt_stall,  m_cs);
        chk("cnt_bubble", hif.cnt_bubble, m_cb);
        chk("cnt_flush",  hif.cnt_flush,  m_cf);
        @(posedge clk);
        if (!rst) begin
            if (e_haz) begin
                if (hif.branch_i != 0) m_pend = hif.branch_i;
            end else if (e_br != 0) begin
                m_pend = 0;
            end
            if (e_haz)     m_cs = sat_inc(m_cs);
            if (e_lw)      m_cb = sat_inc(m_cb);
            if (e_br != 0) m_cf = sat_inc(m_cf);
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        hif.im_stall = 0; hif.dm_stall = 0; hif.branch_i = 0;
        hif.ifid_rs1 = 0; hif.ifid_rs2 = 0; hif.ifid_use_rs1 = 0; hif.ifid_use_rs2 = 0;
        hif.idex_rd = 0; hif.idex_mem_read = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        hif.idex_mem_read = 1; hif.idex_rd = rd; hif.ifid_rs2 = 5; hif.ifid_use_rs2 = 1;
    endtask

    initial begin
        m_pend = 0; m_cs = 0; m_cb = 0; m_cf = 0;
        idle_in();
        @(negedge clk);
        step();                               // reset asserted: forced outputs
        rst = 0;
        for (int i = 0; i < 10; i++) step();  // quiet pipeline

        set_lu(5'd5); step();                 // load-use bubble
        idle_in(); step();
        chk("bubble_count", hif.cnt_bubble, 32'd1);
        set_lu(5'd0); step();                 // x0 never a dependency
        idle_in(); step();

        hif.dm_stall = 1; step();             // stall with redirect held
        hif.branch_i = 2'b10; step();
        hif.branch_i = 2'b00; step();
        step();
        hif.dm_stall = 0; step();             // held jal applied here
        chk("held_flush_count", hif.cnt_flush, 32'd1);
        chk("held_stall_count", hif.cnt_stall, 32'd4);

        set_lu(5'd5); hif.branch_i = 2'b01; step();  // redirect beats load-use
        idle_in(); step();

        hif.im_stall = 1; hif.branch_i = 2'b11; step();  // reset during WAIT
        hif.branch_i = 2'b00; rst = 1; step();
        rst = 0; idle_in(); step();
        step();

        // Saturation: preload the stall counter to all-ones
        force dut.cnt_stall_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_stall_q;
        m_cs = 32'hFFFF_FFFF;
        hif.im_stall = 1; step(); step();
        hif.im_stall = 0; step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            hif.im_stall      = ($urandom_range(0, 7) == 0);
            hif.dm_stall      = ($urandom_range(0, 5) == 0);
            hif.branch_i      = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hif.ifid_rs1      = 5'($urandom_range(0, 3));
            hif.ifid_rs2      = 5'($urandom_range(0, 3));
            hif.ifid_use_rs1  = 1'($urandom);
            hif.ifid_use_rs2  = 1'($urandom);
            hif.idex_rd       = 5'($urandom_range(0, 3));
            hif.idex_mem_read = 1'($urandom);
            if ($urandom_range(0, 60) == 0) rst = 1;
            step();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
